argon_regfile_sequencer: RTL and testbench
==========================================

Name: argon_regfile_sequencer

Overview:
- Control-side counterpart of the Argon register file.
- Accepts a three-register operation request (sources A, B; destination C) and drives the regfile select, output and latch control wires plus bus write data.
- Captures both operands from the bus and hands them to an external execute unit over a valid/ready handshake.
- Writes the returned result back to register C.
- Sits between instruction decode and the regfile/ALU datapath.

Parameters:
- WORD_W, 16, data word width; equals word_t width.
- RES_TIMEOUT, 255, max cycles spent in WAIT_RES before abort; 0 disables timeout.

Ports:
- i_Clk  in  1  clock, rising edge
- i_Reset  in  1  synchronous active-high reset
- i_req_valid  in  1  operation request valid
- o_req_ready  out  1  high only in IDLE
- i_req_idxA  in  4  source A register index
- i_req_idxB  in  4  source B register index
- i_req_idxC  in  4  destination register index
- o_bus_data  out  WORD_W  data driven onto regfile i_data; 0 when not driving
- o_bus_drive  out  1  high in SELECT and WRITE only
- i_bus_data  in  WORD_W  regfile o_data
- o_selectLatch  out  1  regfile index latch strobe
- o_outputA  out  1  regfile output A strobe
- o_outputB  out  1  regfile output B strobe
- o_latchC  out  1  regfile write-C strobe
- o_opnd_valid  out  1  operands valid to execute unit
- i_opnd_ready  in  1  execute unit accepts operands
- o_opnd_a  out  WORD_W  captured A
- o_opnd_b  out  WORD_W  captured B
- i_res_valid  in  1  result valid
- i_res_data  in  WORD_W  result
- o_busy  out  1  state != IDLE
- o_done  out  1  one-cycle pulse at end of every accepted op
- o_err  out  1  one-cycle pulse, with o_done, on timeout abort

Behaviour:
- Reset, synchronous: state = IDLE; every output 0 except o_req_ready = 1; operand and index registers 0; timer 0.
- Reset mid-operation abandons the op. No strobe is asserted in the following cycle, so no partial write occurs.
- States: IDLE, SELECT, RD_A, RD_B, CAP_B, OPND, WAIT_RES, WRITE, DONE.
- IDLE: on i_req_valid & o_req_ready, latch indices → SELECT.
- SELECT, 1 cycle: o_bus_data = {0, idxC, idxB, idxA} (bits 3:0 A, 7:4 B, 11:8 C, upper bits 0); o_bus_drive = 1; o_selectLatch = 1.
- RD_A, 1 cycle: o_outputA = 1.
- RD_B, 1 cycle: o_outputB = 1; capture i_bus_data into opnd_a. The regfile output is registered, so A is visible here.
- CAP_B, 1 cycle: capture i_bus_data into opnd_b.
- OPND: o_opnd_valid = 1, held with stable operands until i_opnd_ready.
  - If i_res_valid is also high on the accept cycle, take the result and go to WRITE.
  - Otherwise go to WAIT_RES.
- WAIT_RES: timer increments each cycle.
  - i_res_valid → latch i_res_data, go to WRITE.
  - Timer reaches RES_TIMEOUT (nonzero) without i_res_valid → DONE with err flag.
  - i_res_valid on the timeout cycle: result wins.
- WRITE, 1 cycle: o_bus_data = result, o_bus_drive = 1, o_latchC = 1.
- DONE, 1 cycle: o_done = 1; o_err = err flag → IDLE.
- Strobe rules: at most one of o_selectLatch/o_outputA/o_outputB/o_latchC is high in any cycle. The regfile prioritises them, so overlap is forbidden.
- Minimum latency, request accept to o_done: 7 cycles (IDLE accept, SELECT, RD_A, RD_B, CAP_B, OPND with same-cycle result, WRITE; DONE is the 7th). Back-to-back ops: next accept in the cycle after DONE.
- Index 0 handling: the regfile returns 0 and ignores writes to index 0; the sequencer still runs all cycles (see Optional Feature).

Optional Feature:
- ARGON_SEQ_ZERO_SKIP_EN defined:
  - idxA == 0 skips RD_A, with opnd_a = 0.
  - idxB == 0 skips the RD_B strobe and CAP_B capture, with opnd_b = 0.
  - The state still passes through the capture point for any nonzero index.
  - idxC == 0 skips WRITE: result is accepted and discarded, o_done still pulses.
- Undefined: fixed sequence as above.

Decomposition:
- argon_pkg: word_t, reg_idx_t (4-bit), seq_state_t enum, SEL_A_LSB/SEL_B_LSB/SEL_C_LSB field offsets (0/4/8).
- One sub-module, argon_seq_timer: clear, enable, terminal count at RES_TIMEOUT, disabled when 0.

Test Plan:
- Basic op: regfile R3 = 0x1234, R5 = 0x0011, req A=3 B=5 C=7; execute unit returns A+B with same-cycle ready → o_opnd_a = 0x1234, o_opnd_b = 0x0011, R7 = 0x1245, o_done 7 cycles after accept, one-hot strobes each cycle.
- Backpressure: hold i_opnd_ready low 4 cycles → o_opnd_valid held, operands stable, no strobes; result 0xBEEF written to C.
- Timeout: RES_TIMEOUT = 3, no i_res_valid → o_done and o_err pulse together, o_latchC never asserted, destination unchanged.
- Zero indices: req A=0 B=2 C=0 → o_opnd_a = 0. With ARGON_SEQ_ZERO_SKIP_EN: no o_outputA, no o_latchC, latency reduced accordingly.
- Reset during WAIT_RES → next cycle IDLE, o_req_ready = 1, o_latchC = 0; a later result pulse is ignored.
- Back-to-back requests with i_req_valid held → second accept exactly one cycle after first o_done; select word 0x0321 for A=1 B=2 C=3.

Source files
------------

// File: rtl/argon_pkg.sv
// Shared types and constants for the Argon register-file sequencer.
package argon_pkg;

    localparam int unsigned WordW = 16;

    typedef logic [WordW-1:0] word_t;
    typedef logic [3:0]       reg_idx_t;

    typedef enum logic [3:0] {
        StIdle,
        StSelect,
        StRdA,
        StRdB,
        StCapB,
        StOpnd,
        StWaitRes,
        StWrite,
        StDone
    } seq_state_t;

    // Field offsets of the register indices inside the select word.
    localparam int unsigned SEL_A_LSB = 0;
    localparam int unsigned SEL_B_LSB = 4;
    localparam int unsigned SEL_C_LSB = 8;

endpackage

// File: rtl/argon_seq_timer.sv
// Result-wait timer: counts cycles while enabled and flags the cycle on which the
// RES_TIMEOUT-th wait cycle is reached. RES_TIMEOUT = 0 disables expiry.
module argon_seq_timer #(
    parameter int unsigned RES_TIMEOUT = 255
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic clear_i,
    input  logic en_i,
    output logic expired_o
);

    // Counter only needs to hold 0 .. RES_TIMEOUT-1.
    localparam int unsigned CntW = (RES_TIMEOUT > 1) ? $clog2(RES_TIMEOUT) : 1;
    localparam logic [CntW-1:0] Terminal = CntW'(RES_TIMEOUT - 1);
    localparam bit Enabled = (RES_TIMEOUT != 0);

    logic [CntW-1:0] count_q, count_d;
    logic            hit;

    assign hit       = Enabled && (count_q == Terminal);
    assign expired_o = en_i && hit;

    // Next count: clear wins, saturate at the terminal value.
    always_comb begin
        count_d = count_q;
        if (clear_i) begin
            count_d = '0;
        end else if (en_i && !hit) begin
            count_d = count_q + CntW'(1);
        end
    end

    // Count register with synchronous reset.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/argon_regfile_sequencer.sv
// Argon register-file sequencer: reads two source registers over the shared bus,
// hands them to an execute unit, and writes the result back to the destination.
// Optional build macro ARGON_SEQ_ZERO_SKIP_EN skips regfile cycles for index 0.
module argon_regfile_sequencer
    import argon_pkg::*;
#(
    parameter int unsigned WORD_W      = 16,
    parameter int unsigned RES_TIMEOUT = 255
) (
    input  logic              i_Clk,
    input  logic              i_Reset,
    input  logic              i_req_valid,
    output logic              o_req_ready,
    input  logic [3:0]        i_req_idxA,
    input  logic [3:0]        i_req_idxB,
    input  logic [3:0]        i_req_idxC,
    output logic [WORD_W-1:0] o_bus_data,
    output logic              o_bus_drive,
    input  logic [WORD_W-1:0] i_bus_data,
    output logic              o_selectLatch,
    output logic              o_outputA,
    output logic              o_outputB,
    output logic              o_latchC,
    output logic              o_opnd_valid,
    input  logic              i_opnd_ready,
    output logic [WORD_W-1:0] o_opnd_a,
    output logic [WORD_W-1:0] o_opnd_b,
    input  logic              i_res_valid,
    input  logic [WORD_W-1:0] i_res_data,
    output logic              o_busy,
    output logic              o_done,
    output logic              o_err
);

`ifdef ARGON_SEQ_ZERO_SKIP_EN
    localparam bit ZeroSkip = 1'b1;
`else
    localparam bit ZeroSkip = 1'b0;
`endif

    seq_state_t        state_q, state_d;
    reg_idx_t          idx_a_q, idx_a_d;
    reg_idx_t          idx_b_q, idx_b_d;
    reg_idx_t          idx_c_q, idx_c_d;
    logic [WORD_W-1:0] opnd_a_q, opnd_a_d;
    logic [WORD_W-1:0] opnd_b_q, opnd_b_d;
    logic [WORD_W-1:0] res_q, res_d;
    logic              err_q, err_d;

    logic skip_a, skip_b, skip_c;
    logic timer_expired;

    // Register 0 always reads 0 and ignores writes, so its cycles can be dropped.
    assign skip_a = ZeroSkip && (idx_a_q == '0);
    assign skip_b = ZeroSkip && (idx_b_q == '0);
    assign skip_c = ZeroSkip && (idx_c_q == '0);

    assign o_opnd_a = opnd_a_q;
    assign o_opnd_b = opnd_b_q;
    assign o_busy   = (state_q != StIdle);

    argon_seq_timer #(
        .RES_TIMEOUT (RES_TIMEOUT)
    ) u_timer (
        .clk_i     (i_Clk),
        .rst_i     (i_Reset),
        .clear_i   (state_q != StWaitRes),
        .en_i      (state_q == StWaitRes),
        .expired_o (timer_expired)
    );

    // Next-state, datapath capture and Moore outputs for the sequencer FSM.
    always_comb begin
        state_d  = state_q;
        idx_a_d  = idx_a_q;
        idx_b_d  = idx_b_q;
        idx_c_d  = idx_c_q;
        opnd_a_d = opnd_a_q;
        opnd_b_d = opnd_b_q;
        res_d    = res_q;
        err_d    = err_q;

        o_req_ready   = 1'b0;
        o_bus_data    = '0;
        o_bus_drive   = 1'b0;
        o_selectLatch = 1'b0;
        o_outputA     = 1'b0;
        o_outputB     = 1'b0;
        o_latchC      = 1'b0;
        o_opnd_valid  = 1'b0;
        o_done        = 1'b0;
        o_err         = 1'b0;

        case (state_q)
            StIdle: begin
                o_req_ready = 1'b1;
                if (i_req_valid) begin
                    idx_a_d  = i_req_idxA;
                    idx_b_d  = i_req_idxB;
                    idx_c_d  = i_req_idxC;
                    opnd_a_d = '0;
                    opnd_b_d = '0;
                    res_d    = '0;
                    err_d    = 1'b0;
                    state_d  = StSelect;
                end
            end
            StSelect: begin
                o_bus_data[SEL_A_LSB +: 4] = idx_a_q;
                o_bus_data[SEL_B_LSB +: 4] = idx_b_q;
                o_bus_data[SEL_C_LSB +: 4] = idx_c_q;
                o_bus_drive   = 1'b1;
                o_selectLatch = 1'b1;
                if (!skip_a) begin
                    state_d = StRdA;
                end else if (!skip_b) begin
                    state_d = StRdB;
                end else begin
                    state_d = StOpnd;
                end
            end
            StRdA: begin
                o_outputA = 1'b1;
                state_d   = StRdB;
            end
            StRdB: begin
                // Regfile output is registered: A appears the cycle after its strobe.
                o_outputB = !skip_b;
                if (!skip_a) begin
                    opnd_a_d = i_bus_data;
                end
                state_d = skip_b ? StOpnd : StCapB;
            end
            StCapB: begin
                opnd_b_d = i_bus_data;
                state_d  = StOpnd;
            end
            StOpnd: begin
                o_opnd_valid = 1'b1;
                if (i_opnd_ready) begin
                    if (i_res_valid) begin
                        res_d   = i_res_data;
                        state_d = skip_c ? StDone : StWrite;
                    end else begin
                        state_d = StWaitRes;
                    end
                end
            end
            StWaitRes: begin
                // A result arriving on the expiry cycle takes priority over the abort.
                if (i_res_valid) begin
                    res_d   = i_res_data;
                    state_d = skip_c ? StDone : StWrite;
                end else if (timer_expired) begin
                    err_d   = 1'b1;
                    state_d = StDone;
                end
            end
            StWrite: begin
                o_bus_data  = res_q;
                o_bus_drive = 1'b1;
                o_latchC    = 1'b1;
                state_d     = StDone;
            end
            StDone: begin
                o_done  = 1'b1;
                o_err   = err_q;
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // State and datapath registers with synchronous reset.
    always_ff @(posedge i_Clk) begin
        if (i_Reset) begin
            state_q  <= StIdle;
            idx_a_q  <= '0;
            idx_b_q  <= '0;
            idx_c_q  <= '0;
            opnd_a_q <= '0;
            opnd_b_q <= '0;
            res_q    <= '0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            idx_a_q  <= idx_a_d;
            idx_b_q  <= idx_b_d;
            idx_c_q  <= idx_c_d;
            opnd_a_q <= opnd_a_d;
            opnd_b_q <= opnd_b_d;
            res_q    <= res_d;
            err_q    <= err_d;
        end
    end

endmodule

// File: tb/tb_argon_regfile_sequencer.sv
// Directed bench for argon_regfile_sequencer with a behavioural regfile model.
module tb_argon_regfile_sequencer;

    localparam int unsigned WordW      = 16;
    localparam int unsigned ResTimeout = 3;

    logic             clk = 1'b0;
    logic             i_Reset;
    logic             i_req_valid;
    logic             o_req_ready;
    logic [3:0]       i_req_idxA, i_req_idxB, i_req_idxC;
    logic [WordW-1:0] o_bus_data;
    logic             o_bus_drive;
    logic [WordW-1:0] i_bus_data;
    logic             o_selectLatch, o_outputA, o_outputB, o_latchC;
    logic             o_opnd_valid;
    logic             i_opnd_ready;
    logic [WordW-1:0] o_opnd_a, o_opnd_b;
    logic             i_res_valid;
    logic [WordW-1:0] i_res_data;
    logic             o_busy, o_done, o_err;

    always #5 clk = ~clk;

    argon_regfile_sequencer #(
        .WORD_W      (WordW),
        .RES_TIMEOUT (ResTimeout)
    ) dut (
        .i_Clk         (clk),
        .i_Reset       (i_Reset),
        .i_req_valid   (i_req_valid),
        .o_req_ready   (o_req_ready),
        .i_req_idxA    (i_req_idxA),
        .i_req_idxB    (i_req_idxB),
        .i_req_idxC    (i_req_idxC),
        .o_bus_data    (o_bus_data),
        .o_bus_drive   (o_bus_drive),
        .i_bus_data    (i_bus_data),
        .o_selectLatch (o_selectLatch),
        .o_outputA     (o_outputA),
        .o_outputB     (o_outputB),
        .o_latchC      (o_latchC),
        .o_opnd_valid  (o_opnd_valid),
        .i_opnd_ready  (i_opnd_ready),
        .o_opnd_a      (o_opnd_a),
        .o_opnd_b      (o_opnd_b),
        .i_res_valid   (i_res_valid),
        .i_res_data    (i_res_data),
        .o_busy        (o_busy),
        .o_done        (o_done),
        .o_err         (o_err)
    );

    // Regfile model: index latch, registered output, index 0 reads 0 and ignores writes.
    logic [15:0] rf [16] = '{16'h0000, 16'h0101, 16'h0222, 16'h1234, 16'h0000, 16'h0011,
                             16'h6666, 16'h0000, 16'h0000, 16'h0A0A, 16'h0505, 16'h0000,
                             16'h0000, 16'h7777, 16'h0000, 16'h0000};
    logic [3:0]  rf_sa = 4'd0, rf_sb = 4'd0, rf_sc = 4'd0;
    logic [15:0] rf_out = 16'h0;

    assign i_bus_data = rf_out;

    always @(posedge clk) begin
        if (o_selectLatch) begin
            rf_sa <= o_bus_data[3:0];
            rf_sb <= o_bus_data[7:4];
            rf_sc <= o_bus_data[11:8];
        end
        if (o_outputA) rf_out <= rf[rf_sa];
        else if (o_outputB) rf_out <= rf[rf_sb];
        if (o_latchC && rf_sc != 4'd0) rf[rf_sc] <= o_bus_data;
    end

    // Protocol monitor sampled mid-cycle.
    int n_sel = 0, n_outa = 0, n_outb = 0, n_latchc = 0;
    int n_overlap = 0, n_opnd_strobe = 0, n_err_alone = 0, n_bus_bad = 0;
    logic [15:0] last_sel = 16'h0;

    always @(negedge clk) begin
        n_sel    += int'(o_selectLatch);
        n_outa   += int'(o_outputA);
        n_outb   += int'(o_outputB);
        n_latchc += int'(o_latchC);
        if ($countones({o_selectLatch, o_outputA, o_outputB, o_latchC}) > 1) n_overlap++;
        if (o_opnd_valid && (o_selectLatch | o_outputA | o_outputB | o_latchC)) n_opnd_strobe++;
        if (o_err && !o_done) n_err_alone++;
        if (o_bus_drive !== (o_selectLatch | o_latchC)) n_bus_bad++;
        if (!o_bus_drive && o_bus_data !== 16'h0) n_bus_bad++;
        if (o_selectLatch) last_sel = o_bus_data;
    end

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Issue one request and play the execute unit until o_done (bounded).
    task automatic run_op(input string tag, input logic [3:0] a, input logic [3:0] b,
                          input logic [3:0] c, input int rdy_delay, input int res_delay,
                          input bit add_res, input logic [15:0] res_val, input bit hold,
                          output int lat, output bit err_seen, output logic [15:0] cap_a,
                          output logic [15:0] cap_b, output int unstable,
                          output int opnd_cycles);
        bit seen_opnd = 0, hs_seen = 0, done_seen = 0;
        int since_hs = 0, opnd_wait = 0, guard = 0;
        lat = 0; err_seen = 0; cap_a = '0; cap_b = '0; unstable = 0; opnd_cycles = 0;
        while (!o_req_ready && guard < 20) begin
            tick();
            guard++;
        end
        i_req_valid = 1'b1;
        i_req_idxA  = a;
        i_req_idxB  = b;
        i_req_idxC  = c;
        tick();
        lat = 1;
        if (!hold) i_req_valid = 1'b0;
        for (int k = 0; k < 60; k++) begin
            if (o_done) begin
                done_seen = 1;
                err_seen  = o_err;
                break;
            end
            i_opnd_ready = 1'b0;
            i_res_valid  = 1'b0;
            if (hs_seen) since_hs++;
            if (o_opnd_valid) begin
                opnd_cycles++;
                if (!seen_opnd) begin
                    cap_a = o_opnd_a;
                    cap_b = o_opnd_b;
                    seen_opnd = 1;
                end else if (o_opnd_a !== cap_a || o_opnd_b !== cap_b) begin
                    unstable++;
                end
                if (opnd_wait >= rdy_delay) begin
                    i_opnd_ready = 1'b1;
                    hs_seen  = 1;
                    since_hs = 0;
                end
                opnd_wait++;
            end
            if (hs_seen && res_delay >= 0 && since_hs == res_delay) begin
                i_res_valid = 1'b1;
                i_res_data  = add_res ? (cap_a + cap_b) : res_val;
            end
            tick();
            lat++;
        end
        i_opnd_ready = 1'b0;
        i_res_valid  = 1'b0;
        check_eq({tag, "_done"}, 32'(done_seen), 32'd1);
        if (!hold) tick();
    endtask

    int          lat, unstable, opnd_cycles;
    bit          err_seen;
    logic [15:0] cap_a, cap_b;
    int          s_sel, s_outa, s_outb, s_latchc;

    task automatic snap();
        s_sel = n_sel; s_outa = n_outa; s_outb = n_outb; s_latchc = n_latchc;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        i_Reset = 1'b1; i_req_valid = 1'b0; i_req_idxA = '0; i_req_idxB = '0; i_req_idxC = '0;
        i_opnd_ready = 1'b0; i_res_valid = 1'b0; i_res_data = '0;
        tick(); tick();
        i_Reset = 1'b0;

        // Reset state.
        check_eq("rst_ctrl", 32'({o_selectLatch, o_outputA, o_outputB, o_latchC, o_bus_drive,
                                  o_opnd_valid, o_done, o_err, o_busy, o_req_ready}), 32'h1);
        check_eq("rst_bus", 32'(o_bus_data), 32'h0);
        check_eq("rst_opnd_a", 32'(o_opnd_a), 32'h0);
        check_eq("rst_opnd_b", 32'(o_opnd_b), 32'h0);

        // Basic op: R7 = R3 + R5.
        snap();
        run_op("basic", 4'd3, 4'd5, 4'd7, 0, 0, 1'b1, 16'h0, 1'b0,
               lat, err_seen, cap_a, cap_b, unstable, opnd_cycles);
        check_eq("basic_lat", 32'(lat), 32'd7);
        check_eq("basic_opnd_a", 32'(cap_a), 32'h1234);
        check_eq("basic_opnd_b", 32'(cap_b), 32'h0011);
        check_eq("basic_sel_word", 32'(last_sel), 32'h0753);
        check_eq("basic_err", 32'(err_seen), 32'd0);
        check_eq("basic_r7", 32'(rf[7]), 32'h1245);
        check_eq("basic_strobes", 32'({8'(n_sel - s_sel), 8'(n_outa - s_outa),
                                       8'(n_outb - s_outb), 8'(n_latchc - s_latchc)}),
                 32'h01010101);
        check_eq("basic_idle", 32'({o_busy, o_req_ready}), 32'b01);

        // Backpressure: ready low 4 cycles, result one cycle after accept.
        run_op("bp", 4'd9, 4'd10, 4'd11, 4, 1, 1'b0, 16'hBEEF, 1'b0,
               lat, err_seen, cap_a, cap_b, unstable, opnd_cycles);
        check_eq("bp_lat", 32'(lat), 32'd12);
        check_eq("bp_opnd_cycles", 32'(opnd_cycles), 32'd5);
        check_eq("bp_stable", 32'(unstable), 32'd0);
        check_eq("bp_opnd", 32'({cap_a, cap_b}), 32'h0A0A0505);
        check_eq("bp_r11", 32'(rf[11]), 32'hBEEF);

        // Timeout: no result within three wait cycles.
        snap();
        run_op("tmo", 4'd2, 4'd4, 4'd13, 0, -1, 1'b0, 16'h0, 1'b0,
               lat, err_seen, cap_a, cap_b, unstable, opnd_cycles);
        check_eq("tmo_lat", 32'(lat), 32'd9);
        check_eq("tmo_err", 32'(err_seen), 32'd1);
        check_eq("tmo_no_latchc", 32'(n_latchc - s_latchc), 32'd0);
        check_eq("tmo_r13", 32'(rf[13]), 32'h7777);

        // Result arriving on the expiry cycle wins.
        run_op("tmo_win", 4'd2, 4'd4, 4'd14, 0, 3, 1'b0, 16'h5A5A, 1'b0,
               lat, err_seen, cap_a, cap_b, unstable, opnd_cycles);
        check_eq("tmo_win_lat", 32'(lat), 32'd10);
        check_eq("tmo_win_err", 32'(err_seen), 32'd0);
        check_eq("tmo_win_r14", 32'(rf[14]), 32'h5A5A);

        // Zero indices.
        snap();
        run_op("zero", 4'd0, 4'd2, 4'd0, 0, 0, 1'b0, 16'h3333, 1'b0,
               lat, err_seen, cap_a, cap_b, unstable, opnd_cycles);
        check_eq("zero_opnd_a", 32'(cap_a), 32'h0);
        check_eq("zero_opnd_b", 32'(cap_b), 32'h0222);
        check_eq("zero_r0", 32'(rf[0]), 32'h0);
`ifdef ARGON_SEQ_ZERO_SKIP_EN
        check_eq("zero_lat", 32'(lat), 32'd5);
        check_eq("zero_outa", 32'(n_outa - s_outa), 32'd0);
        check_eq("zero_latchc", 32'(n_latchc - s_latchc), 32'd0);
`else
        check_eq("zero_lat", 32'(lat), 32'd7);
        check_eq("zero_outa", 32'(n_outa - s_outa), 32'd1);
        check_eq("zero_latchc", 32'(n_latchc - s_latchc), 32'd1);
`endif

        // Reset while waiting for the result.
        begin
            bit seen = 0;
            bit in_wait = 0;
            i_req_valid = 1'b1; i_req_idxA = 4'd3; i_req_idxB = 4'd5; i_req_idxC = 4'd6;
            i_opnd_ready = 1'b1;
            tick();
            i_req_valid = 1'b0;
            for (int k = 0; k < 20; k++) begin
                if (o_opnd_valid) seen = 1;
                else if (seen && o_busy) begin
                    in_wait = 1;
                    break;
                end
                tick();
            end
            check_eq("rstw_reached_wait", 32'(in_wait), 32'd1);
            i_opnd_ready = 1'b0;
            snap();
            i_Reset = 1'b1;
            tick();
            i_Reset = 1'b0;
            check_eq("rstw_idle", 32'({o_req_ready, o_busy, o_latchC}), 32'b100);
            i_res_valid = 1'b1; i_res_data = 16'hDEAD;
            tick();
            i_res_valid = 1'b0;
            check_eq("rstw_still_idle", 32'({o_busy, o_done}), 32'b00);
            tick(); tick();
            check_eq("rstw_r6", 32'(rf[6]), 32'h6666);
            check_eq("rstw_no_latchc", 32'(n_latchc - s_latchc), 32'd0);
        end

        // Back-to-back with request valid held.
        run_op("b2b1", 4'd1, 4'd2, 4'd3, 0, 0, 1'b0, 16'h0F0F, 1'b1,
               lat, err_seen, cap_a, cap_b, unstable, opnd_cycles);
        check_eq("b2b1_lat", 32'(lat), 32'd7);
        check_eq("b2b1_r3", 32'(rf[3]), 32'h0F0F);
        tick();
        check_eq("b2b_accept_cycle", 32'(o_req_ready), 32'd1);
        tick();
        check_eq("b2b_select", 32'({15'h0, o_selectLatch, o_bus_data}), 32'h10321);
        i_req_valid = 1'b0;
        begin
            bit done2 = 0;
            i_opnd_ready = 1'b1; i_res_valid = 1'b1; i_res_data = 16'h1111;
            for (int k = 0; k < 20; k++) begin
                if (o_done) begin
                    done2 = 1;
                    break;
                end
                tick();
            end
            i_opnd_ready = 1'b0; i_res_valid = 1'b0;
            check_eq("b2b2_done", 32'(done2), 32'd1);
            check_eq("b2b2_r3", 32'(rf[3]), 32'h1111);
        end
        tick();

        // Whole-run protocol rules.
        check_eq("strobe_onehot", 32'(n_overlap), 32'd0);
        check_eq("opnd_no_strobe", 32'(n_opnd_strobe), 32'd0);
        check_eq("err_with_done", 32'(n_err_alone), 32'd0);
        check_eq("bus_drive_rule", 32'(n_bus_bad), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
